sw_debounce: RTL and testbench



---
 rtl/sw_debounce_pkg.sv | 23 ++
 rtl/sw_debounce_bit.sv | 91 +++++++++
 rtl/sw_debounce.sv | 67 ++++++
 tb/tb_sw_debounce.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// ---------------------------------------------------------------------------
// sw_debounce_pkg
// Shared constants and helpers for the slide-switch input conditioner.
//   SW_DEBOUNCE_DEFAULT_CYCLES : stable cycles needed before a new level is
//                                accepted (10 ms at 100 MHz)
//   SW_SYNC_DEFAULT_STAGES     : default synchronizer depth
//   sw_cnt_width()             : stability counter width for a cycle count
// No ports (package).
// ---------------------------------------------------------------------------
package sw_debounce_pkg;

    localparam int SW_DEBOUNCE_DEFAULT_CYCLES = 1_000_000;
    localparam int SW_SYNC_DEFAULT_STAGES     = 2;

    // The counter must be able to hold DEBOUNCE_CYCLES-1. Sizing it for
    // cycles+1 values keeps a spare code and never yields a zero width.
    function automatic int sw_cnt_width(input int cycles);
        if (cycles < 1)
            return 1;
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// ---------------------------------------------------------------------------
// sw_debounce_bit
// One switch channel: synchronizer chain, stability counter, stable level
// register and (optionally) registered rise/fall pulses.
// Build option: SW_DEBOUNCE_EDGE_EN builds the edge pulse flops and the
// 'accept' port; without it rise/fall are constant 0.
// Ports:
//   clk    : system clock
//   rst    : synchronous active-high reset
//   din    : raw asynchronous switch level
//   level  : debounced level
//   rise   : one-cycle pulse on an accepted 0->1 change
//   fall   : one-cycle pulse on an accepted 1->0 change
//   accept : (edge build only) combinational "level changes on this edge",
//            used by the top to register change_o alongside rise/fall
// ---------------------------------------------------------------------------
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = SW_SYNC_DEFAULT_STAGES,
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
`ifdef SW_DEBOUNCE_EDGE_EN
    ,
    output logic accept
`endif
);

    localparam int CW = sw_cnt_width(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] syncChain;
    logic                   syncLevel;
    logic [CW-1:0]          stableCnt;
    logic                   take;

    assign syncLevel = syncChain[SYNC_STAGES-1];

    // The level flips on the edge where the synchronized input has differed
    // from the stable level for the whole window (counter at its last value).
    assign take = (syncLevel != level) && (stableCnt == CW'(DEBOUNCE_CYCLES - 1));

    // Metastability chain; the raw input enters at bit 0.
    always_ff @(posedge clk) begin
        if (rst)
            syncChain <= '0;
        else
            syncChain <= {syncChain[SYNC_STAGES-2:0], din};
    end

    // Stability counter and accepted level. Any agreement between the
    // synchronized input and the level clears the count, so a bounce
    // restarts the full window.
    always_ff @(posedge clk) begin
        if (rst) begin
            level     <= 1'b0;
            stableCnt <= '0;
        end else if (syncLevel == level) begin
            stableCnt <= '0;
        end else if (take) begin
            level     <= syncLevel;
            stableCnt <= '0;
        end else begin
            stableCnt <= stableCnt + CW'(1);
        end
    end

`ifdef SW_DEBOUNCE_EDGE_EN
    assign accept = take;

    // Edge pulses are registered on the same edge that updates the level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= take & syncLevel;
            fall <= take & ~syncLevel;
        end
    end
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce.sv
// ---------------------------------------------------------------------------
// sw_debounce
// Synchronizes and debounces WIDTH slide-switch lines independently and
// reports clean levels plus single-cycle rise/fall pulses.
// Build option: SW_DEBOUNCE_EDGE_EN enables rise_o/fall_o/change_o; when
// undefined they are tied to 0 and sw_o behaves identically.
// Ports:
//   clk      : system clock
//   rst      : synchronous active-high reset
//   sw_i     : raw switch levels (asynchronous)
//   sw_o     : debounced levels
//   rise_o   : per-bit one-cycle pulse on accepted 0->1
//   fall_o   : per-bit one-cycle pulse on accepted 1->0
//   change_o : OR of all rise_o|fall_o bits, aligned with those pulses
// ---------------------------------------------------------------------------
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int SYNC_STAGES     = SW_SYNC_DEFAULT_STAGES,
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_i,
    output logic [WIDTH-1:0] sw_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             change_o
);

`ifdef SW_DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] acceptVec;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk    (clk),
            .rst    (rst),
            .din    (sw_i[i]),
            .level  (sw_o[i]),
            .rise   (rise_o[i]),
            .fall   (fall_o[i])
`ifdef SW_DEBOUNCE_EDGE_EN
            ,
            .accept (acceptVec[i])
`endif
        );
    end

`ifdef SW_DEBOUNCE_EDGE_EN
    // Reduced from the channels' pre-register accept terms so change_o lands
    // on the same edge as the registered rise/fall pulses.
    always_ff @(posedge clk) begin
        if (rst)
            change_o <= 1'b0;
        else
            change_o <= |acceptVec;
    end
`else
    assign change_o = 1'b0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// ---------------------------------------------------------------------------
// tb_sw_debounce
// Self-checking bench for sw_debounce with WIDTH=16, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=8. A window-based reference model keeps the history of
// synchronized input values and accepts a new level once the last
// DEBOUNCE_CYCLES samples since reset all disagree with the current level.
// ---------------------------------------------------------------------------
module tb_sw_debounce;

    localparam int W      = 16;
    localparam int SYNC   = 2;
    localparam int DC     = 8;
    localparam int MAXEDG = 4096;

`ifdef SW_DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] swIn = '0;
    logic [W-1:0] sw_o;
    logic [W-1:0] rise_o;
    logic [W-1:0] fall_o;
    logic         change_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int           edgeNo = 0;
    int           lastRst = 0;
    logic [W-1:0] swHist  [0:MAXEDG-1];
    bit           rstHist [0:MAXEDG-1];
    logic [W-1:0] sHist   [0:MAXEDG-1];
    logic [W-1:0] expSw = '0;
    logic [W-1:0] expRise = '0;
    logic [W-1:0] expFall = '0;
    logic         expChange = 1'b0;

    sw_debounce #(
        .WIDTH           (W),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_i     (swIn),
        .sw_o     (sw_o),
        .rise_o   (rise_o),
        .fall_o   (fall_o),
        .change_o (change_o)
    );

    always #5 clk = ~clk;

    // Advance the reference model by one clock edge with the inputs that
    // were present before that edge.
    task automatic modelEdge(input logic [W-1:0] sw, input logic r);
        bit steady;
        edgeNo++;
        if (edgeNo >= MAXEDG) begin
            $display("[TB] FAIL model_capacity: edge %0d exceeds history %0d", edgeNo, MAXEDG);
            $fatal(1, "[TB] history overflow");
        end
        swHist[edgeNo]  = sw;
        rstHist[edgeNo] = r;
        expRise = '0;
        expFall = '0;
        if (r) begin
            expSw          = '0;
            lastRst        = edgeNo;
            sHist[edgeNo]  = '0;
        end else begin
            // The value leaving the synchronizer was applied SYNC edges ago,
            // unless a reset cleared the chain in between.
            if (edgeNo <= SYNC || rstHist[edgeNo-1] || rstHist[edgeNo-2])
                sHist[edgeNo] = '0;
            else
                sHist[edgeNo] = swHist[edgeNo-SYNC];
            if (edgeNo - DC + 1 > lastRst) begin
                for (int b = 0; b < W; b++) begin
                    steady = 1'b1;
                    for (int j = edgeNo - DC + 1; j <= edgeNo; j++)
                        if (sHist[j][b] == expSw[b])
                            steady = 1'b0;
                    if (steady) begin
                        expSw[b] = ~expSw[b];
                        if (expSw[b])
                            expRise[b] = 1'b1;
                        else
                            expFall[b] = 1'b1;
                    end
                end
            end
        end
        expChange = |(expRise | expFall);
        if (!EDGE_EN) begin
            expRise   = '0;
            expFall   = '0;
            expChange = 1'b0;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                               input logic [W-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s edge %0d: observed %h expected %h", tag, edgeNo, observed, expected);
        end
    endtask

    task automatic compareModel();
        checkOutput("sw_o",     sw_o,               expSw);
        checkOutput("rise_o",   rise_o,             expRise);
        checkOutput("fall_o",   fall_o,             expFall);
        checkOutput("change_o", {15'd0, change_o},  {15'd0, expChange});
    endtask

    // One clock: drive on the falling edge, update the model on the rising
    // edge, and compare shortly after it.
    task automatic applyStimulus(input logic [W-1:0] sw, input logic r);
        @(negedge clk);
        swIn = sw;
        rst  = r;
        @(posedge clk);
        modelEdge(sw, r);
        #1;
        compareModel();
    endtask

    task automatic applyRepeat(input logic [W-1:0] sw, input logic r, input int n);
        for (int k = 0; k < n; k++)
            applyStimulus(sw, r);
    endtask

    initial begin
        logic [W-1:0] rv;
        logic [W-1:0] edgeMask;

        edgeMask = EDGE_EN ? 16'hFFFF : 16'h0000;

        // Reset hold with all lines high, then debounce from scratch.
        applyRepeat(16'hFFFF, 1'b1, 3);
        checkOutput("reset_sw", sw_o, 16'h0000);
        applyRepeat(16'hFFFF, 1'b0, 9);
        checkOutput("hold_edge9_sw", sw_o, 16'h0000);
        applyStimulus(16'hFFFF, 1'b0);
        checkOutput("hold_edge10_sw", sw_o, 16'hFFFF);
        checkOutput("hold_edge10_rise", rise_o, 16'hFFFF & edgeMask);
        checkOutput("hold_edge10_chg", {15'd0, change_o}, {15'd0, EDGE_EN});
        applyStimulus(16'hFFFF, 1'b0);
        checkOutput("hold_edge11_rise", rise_o, 16'h0000);

        // Return everything to 0 and settle.
        applyRepeat(16'h0000, 1'b0, 12);

        // Clean press and release on bit 3.
        applyRepeat(16'h0008, 1'b0, 9);
        checkOutput("press_edge9_sw", sw_o, 16'h0000);
        applyStimulus(16'h0008, 1'b0);
        checkOutput("press_edge10_sw", sw_o, 16'h0008);
        checkOutput("press_edge10_rise", rise_o, 16'h0008 & edgeMask);
        applyStimulus(16'h0008, 1'b0);
        applyRepeat(16'h0000, 1'b0, 9);
        checkOutput("release_edge9_sw", sw_o, 16'h0008);
        applyStimulus(16'h0000, 1'b0);
        checkOutput("release_edge10_sw", sw_o, 16'h0000);
        checkOutput("release_edge10_fall", fall_o, 16'h0008 & edgeMask);
        applyRepeat(16'h0000, 1'b0, 3);

        // Bounce rejection on bit 5.
        applyRepeat(16'h0020, 1'b0, 5);
        applyRepeat(16'h0000, 1'b0, 2);
        applyRepeat(16'h0020, 1'b0, 7);
        applyRepeat(16'h0000, 1'b0, 1);
        applyRepeat(16'h0020, 1'b0, 9);
        checkOutput("bounce_edge9_sw", sw_o, 16'h0000);
        applyStimulus(16'h0020, 1'b0);
        checkOutput("bounce_edge10_sw", sw_o, 16'h0020);
        applyRepeat(16'h0020, 1'b0, 4);

        // Simultaneous rise on bit 0 and fall on bit 15.
        applyRepeat(16'h8000, 1'b0, 12);
        applyRepeat(16'h0001, 1'b0, 9);
        applyStimulus(16'h0001, 1'b0);
        checkOutput("simul_rise", rise_o, 16'h0001 & edgeMask);
        checkOutput("simul_fall", fall_o, 16'h8000 & edgeMask);
        applyRepeat(16'h0000, 1'b0, 12);

        // Reset in the middle of a debounce window on bit 2.
        applyRepeat(16'h0004, 1'b0, 5);
        applyStimulus(16'h0004, 1'b1);
        applyRepeat(16'h0004, 1'b0, 9);
        checkOutput("midrst_edge9_sw", sw_o, 16'h0000);
        applyStimulus(16'h0004, 1'b0);
        checkOutput("midrst_edge10_sw", sw_o, 16'h0004);

        // Randomized segments: hold a value for a random time, flipping a
        // random sparse set of bits between segments; occasional resets.
        rv = swIn;
        for (int seg = 0; seg < 120; seg++) begin
            rv = rv ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            if ($urandom_range(0, 39) == 0)
                applyRepeat(rv, 1'b1, $urandom_range(1, 2));
            else if ($urandom_range(0, 1) == 0)
                applyRepeat(rv, 1'b0, $urandom_range(1, 6));
            else
                applyRepeat(rv, 1'b0, $urandom_range(7, 20));
        end
        applyRepeat(rv, 1'b0, 12);

        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end

endmodule
